// File: rtl/stream_capture_pkg.sv
// Shared types for the stream capture path: sample/frame shapes and emitter states.
package stream_capture_pkg;

   localparam int DSIZE_DEF  = 32;
   localparam int NUM_CH_DEF = 4;

   typedef logic [DSIZE_DEF-1:0] sample_t;
   typedef sample_t [NUM_CH_DEF-1:0] frame_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GAP    = 2'd1,
      FINISH = 2'd2
   } emit_state_e;

endpackage

// File: rtl/stream_frame_fifo.sv
// First-word-fall-through frame buffer with full/empty flags and occupancy count.
module stream_frame_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == DEPTH_L);
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/stream_frame_packer.sv
// Packs NUM_CH samples per frame, buffers frames and emits each one as a held word
// with strobe/toggle, spaced by MIN_GAP idle clocks, stopping after TRIGGER_TOTAL frames.
module stream_frame_packer
   import stream_capture_pkg::*;
#(
   parameter int DSIZE         = DSIZE_DEF,
   parameter int NUM_CH        = NUM_CH_DEF,
   parameter int FIFO_DEPTH    = 8,
   parameter int MIN_GAP       = 4,
   parameter int TRIGGER_TOTAL = 1000
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      capture_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DSIZE-1:0]          in_data,
   input  logic                      in_last,
   output logic [NUM_CH*DSIZE-1:0]   frame_data,
   output logic                      frame_stb,
   output logic                      frame_toggle,
   output logic                      dump_enable,
   output logic [31:0]               frame_cnt,
   output logic                      done
);

   localparam int FW = NUM_CH * DSIZE;
   localparam int LW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(NUM_CH - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP);
   localparam logic [31:0]   TRIG      = 32'(TRIGGER_TOTAL);

   logic [LW-1:0]                   lane_cnt_r;
   logic [NUM_CH-1:0][DSIZE-1:0]    lane_buf_r;
   logic [NUM_CH-1:0][DSIZE-1:0]    frame_next_s;
   logic [FW-1:0]                   frame_flat_s;
   logic                            run_r;
   logic                            completes_s;
   logic                            in_ready_s;
   logic                            accept_s;
   logic                            push_s;
   logic                            pop_s;
   logic [FW-1:0]                   fifo_rdata_s;
   logic                            fifo_full_s;
   logic                            fifo_empty_s;
   logic [CW-1:0]                   fifo_count_s;
   emit_state_e                     state_r;
   logic [GW-1:0]                   gap_cnt_r;

   // Frame under construction with this beat merged in, plus the acceptance decision.
   always_comb begin
      frame_next_s             = lane_buf_r;
      frame_next_s[lane_cnt_r] = in_data;
      completes_s              = (lane_cnt_r == LAST_LANE) || in_last;
      if (capture_en && run_r && !done) begin
         in_ready_s = !(completes_s && fifo_full_s);
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign frame_flat_s = frame_next_s;
   assign in_ready     = in_ready_s;
   assign accept_s     = in_valid && in_ready_s;
   assign push_s       = accept_s && completes_s;
   // The occupancy count and the empty flag must agree before a frame is consumed.
   assign pop_s        = (state_r == IDLE) && (TRIG != 32'd0) && !fifo_empty_s
                         && (fifo_count_s != '0);

   // Lane assembly; run_r keeps acceptance off for the first cycle after reset.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         lane_cnt_r <= '0;
         lane_buf_r <= '0;
         run_r      <= 1'b0;
      end else begin
         run_r <= 1'b1;
         if (push_s) begin
            lane_cnt_r <= '0;
            lane_buf_r <= '0;
         end else if (accept_s) begin
            lane_cnt_r <= lane_cnt_r + 1'b1;
            lane_buf_r <= frame_next_s;
         end
      end
   end

   stream_frame_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (frame_flat_s),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Emitter: pop -> strobe, then MIN_GAP quiet clocks, until TRIGGER_TOTAL frames are out.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         gap_cnt_r    <= '0;
         frame_data   <= '0;
         frame_stb    <= 1'b0;
         frame_toggle <= 1'b0;
         dump_enable  <= 1'b0;
         frame_cnt    <= '0;
         done         <= 1'b0;
      end else begin
         frame_stb   <= 1'b0;
         dump_enable <= capture_en && !done;
         case (state_r)
            IDLE: begin
               if (TRIG == 32'd0) begin
                  state_r     <= FINISH;
                  done        <= 1'b1;
                  dump_enable <= 1'b0;
               end else if (pop_s) begin
                  frame_data   <= fifo_rdata_s;
                  frame_stb    <= 1'b1;
                  frame_toggle <= ~frame_toggle;
                  if (frame_cnt != 32'hFFFF_FFFF) begin
                     frame_cnt <= frame_cnt + 32'd1;
                  end
                  if ((frame_cnt + 32'd1) == TRIG) begin
                     state_r <= FINISH;
                  end else begin
                     state_r   <= GAP;
                     gap_cnt_r <= GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_r <= GW'(1)) begin
                  state_r <= IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 1'b1;
               end
            end
            FINISH: begin
               done        <= 1'b1;
               dump_enable <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
